pc_update_unit: RTL and testbench
=================================

PC_UPDATE_UNIT -- requirements
Module: pc_update_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC value loaded on reset.
REQ-002 Parameter TRAP_VEC, default 32'h0000_0100, is the PC value loaded on leaving TRAP.
REQ-003 Port clk  input  1  is the single clock; all state updates occur on the rising edge.
REQ-004 Port rst_n  input  1  is the asynchronous, active-low reset.
REQ-005 Port stall  input  1  holds the PC and state when high.
REQ-006 Port branch  input  1  is the decoded conditional-branch flag.
REQ-007 Port zero  input  1  is the ALU compare result; branch taken = branch & zero.
REQ-008 Port jump  input  1  is the decoded JAL flag.
REQ-009 Port jalr  input  1  is the decoded JALR flag.
REQ-010 Port shifted_imm  input  32  is the immediate already shifted left by one, supplied by the shift stage.
REQ-011 Port rs1_val  input  32  is the register operand for JALR.
REQ-012 Port imm  input  32  is the unshifted I-type immediate for JALR.
REQ-013 Port trap_clr  input  1  is a one-cycle pulse that acknowledges a misalignment trap.
REQ-014 Port pc  output  32  is the current PC register value.
REQ-015 Port pc_plus4  output  32  is pc + 4, combinational.
REQ-016 Port fetch_valid  output  1  is high when pc addresses a valid instruction to execute.
REQ-017 Port misalign  output  1  is high while in TRAP.

Function
REQ-018 The unit SHALL implement a three-state FSM: BOOT, RUN, TRAP.
REQ-019 BOOT SHALL last exactly one cycle after reset release, regardless of stall, with pc = RESET_PC and fetch_valid = 0, then move to RUN with pc unchanged.
REQ-020 In RUN, fetch_valid SHALL be 1 and misalign SHALL be 0.
REQ-021 Branch target SHALL be pc + shifted_imm, modulo 2^32, with no overflow flag.
REQ-022 JALR target SHALL be (rs1_val + imm) with bit 0 forced to 0, modulo 2^32.
REQ-023 Next-PC selection priority SHALL be: jalr, then jump (JAL target = pc + shifted_imm), then taken branch, then pc_plus4.
REQ-024 In RUN with stall = 0, pc SHALL load the selected next-PC on the clock edge, giving one-cycle latency.
REQ-025 In RUN with stall = 1, pc and state SHALL hold, and all control inputs SHALL be ignored.
REQ-026 If the selected target is a redirect (jalr, jump, or taken branch) with target[1] = 1, then pc SHALL hold, the state SHALL move to TRAP, and pc_plus4 is never checked.
REQ-027 In TRAP, misalign SHALL be 1, fetch_valid SHALL be 0, pc SHALL hold, and stall and control inputs SHALL be ignored.
REQ-028 trap_clr in TRAP SHALL load pc = TRAP_VEC and move to RUN on that edge; trap_clr in BOOT or RUN SHALL have no effect.
REQ-029 pc wrap-around from 32'hFFFF_FFFC + 4 SHALL yield 32'h0000_0000 with no error.
REQ-030 If several control flags are high simultaneously, only the highest-priority flag SHALL take effect, and misalignment SHALL be judged on the selected target only.

Reset
REQ-031 rst_n low SHALL immediately, without waiting for a clock edge, force state = BOOT, pc = RESET_PC, fetch_valid = 0, and misalign = 0.
REQ-032 Reset asserted mid-operation, including in TRAP, SHALL discard the trap and any pending redirect.
REQ-033 Reset release SHALL be registered on the next rising edge, which begins the single BOOT cycle.

Verification
REQ-034 Stimulus: reset, release, no flags for 3 edges -> required: pc = 0, 0 (BOOT), 4, 8, with fetch_valid rising after the first edge.
REQ-035 Stimulus: pc = 32'h40, branch = 1, zero = 1, shifted_imm = 32'hFFFF_FFF0 -> required: next pc = 32'h30; the same case with zero = 0 -> required: next pc = 32'h44.
REQ-036 Stimulus: pc = 32'h20, jalr = 1, jump = 1, rs1_val = 32'h1001, imm = 32'h4 -> required: next pc = 32'h1004 (jalr wins, bit 0 cleared).
REQ-037 Stimulus: pc = 32'h10, jump = 1, shifted_imm = 32'h6 -> required: pc stays 32'h10, misalign = 1; then trap_clr pulse -> required: pc = 32'h100, misalign = 0.
REQ-038 Stimulus: stall = 1 for 2 cycles with branch taken -> required: pc unchanged; with stall = 0 -> required: branch target loads.
REQ-039 Stimulus: rst_n asserted between clock edges while in TRAP -> required: pc = RESET_PC and misalign = 0 immediately.

Source files
------------

// File: rtl/pc_update_unit.sv
// pc_update_unit: program-counter register with BOOT/RUN/TRAP control, next-PC
// selection (jalr > jal > taken branch > +4) and misaligned-redirect trapping.
module pc_update_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch,
    input  logic        zero,
    input  logic        jump,
    input  logic        jalr,
    input  logic [31:0] shifted_imm,
    input  logic [31:0] rs1_val,
    input  logic [31:0] imm,
    input  logic        trap_clr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_valid,
    output logic        misalign
);
    typedef enum logic [1:0] {BOOT, RUN, TRAP} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        fetch_valid_q, fetch_valid_d;
    logic        misalign_q, misalign_d;
    logic [31:0] rel_target, jalr_sum, jalr_target, sel_target;
    logic        taken, redirect;

    assign pc_plus4    = pc_q + 32'd4;
    assign pc          = pc_q;
    assign fetch_valid = fetch_valid_q;
    assign misalign    = misalign_q;

    always_comb begin
        taken       = branch & zero;
        rel_target  = pc_q + shifted_imm;
        jalr_sum    = rs1_val + imm;
        jalr_target = {jalr_sum[31:1], 1'b0};
        redirect    = jalr | jump | taken;
        sel_target  = jalr ? jalr_target : (jump | taken) ? rel_target : pc_plus4;
        state_d     = state_q;
        pc_d        = pc_q;
        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                // only a redirect can be misaligned; sequential fetch never traps
                if (!stall) begin
                    if (redirect && sel_target[1]) state_d = TRAP;
                    else pc_d = sel_target;
                end
            end
            TRAP: begin
                if (trap_clr) begin
                    state_d = RUN;
                    pc_d    = TRAP_VEC;
                end
            end
            default: state_d = BOOT;
        endcase
        fetch_valid_d = (state_d == RUN);
        misalign_d    = (state_d == TRAP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            fetch_valid_q <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_valid_q <= fetch_valid_d;
            misalign_q    <= misalign_d;
        end
    end
endmodule

// File: tb/tb_pc_update_unit.sv
// tb_pc_update_unit: directed vectors for pc_update_unit; inputs change and
// outputs are sampled on the falling clock edge.
module tb_pc_update_unit;
    logic        clk = 1'b0;
    logic        rst_n, stall, branch, zero, jump, jalr, trap_clr;
    logic [31:0] shifted_imm, rs1_val, imm;
    logic [31:0] pc, pc_plus4;
    logic        fetch_valid, misalign;
    int          checks = 0;
    int          errors = 0;

    pc_update_unit dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .branch(branch), .zero(zero),
        .jump(jump), .jalr(jalr), .shifted_imm(shifted_imm), .rs1_val(rs1_val),
        .imm(imm), .trap_clr(trap_clr), .pc(pc), .pc_plus4(pc_plus4),
        .fetch_valid(fetch_valid), .misalign(misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        stall = 0; branch = 0; zero = 0; jump = 0; jalr = 0; trap_clr = 0;
        shifted_imm = 0; rs1_val = 0; imm = 0;
    endtask

    task automatic st(input logic [31:0] epc, input logic efv, input logic emis, input string tag);
        chk({tag, ".pc"}, pc, epc);
        chk({tag, ".fv"}, {31'd0, fetch_valid}, {31'd0, efv});
        chk({tag, ".mis"}, {31'd0, misalign}, {31'd0, emis});
    endtask

    initial begin
        idle();
        rst_n = 0;
        #3;
        st(32'h0, 0, 0, "rst_async");
        @(negedge clk); @(negedge clk);
        st(32'h0, 0, 0, "rst_hold");
        rst_n = 1;
        #1 st(32'h0, 0, 0, "boot");
        @(negedge clk) st(32'h0, 1, 0, "run0");
        @(negedge clk) st(32'h4, 1, 0, "run4");
        @(negedge clk) st(32'h8, 1, 0, "run8");
        chk("pc_plus4", pc_plus4, 32'hC);
        jump = 1; shifted_imm = 32'h38;
        @(negedge clk) st(32'h40, 1, 0, "jal40");
        idle(); branch = 1; zero = 1; shifted_imm = 32'hFFFF_FFF0;
        @(negedge clk) st(32'h30, 1, 0, "br_taken");
        idle(); jump = 1; shifted_imm = 32'h10;
        @(negedge clk) chk("jal_back40", pc, 32'h40);
        idle(); branch = 1; zero = 0; shifted_imm = 32'hFFFF_FFF0;
        @(negedge clk) chk("br_not_taken", pc, 32'h44);
        idle(); jump = 1; shifted_imm = 32'hFFFF_FFDC;
        @(negedge clk) chk("jal20", pc, 32'h20);
        idle(); jalr = 1; jump = 1; rs1_val = 32'h1001; imm = 32'h4; shifted_imm = 32'h8;
        @(negedge clk) st(32'h1004, 1, 0, "jalr_wins");
        idle(); jalr = 1; rs1_val = 32'h10;
        @(negedge clk) chk("jalr10", pc, 32'h10);
        idle(); jump = 1; shifted_imm = 32'h6;
        @(negedge clk) st(32'h10, 0, 1, "trap");
        idle(); jump = 1; jalr = 1; rs1_val = 32'h500; shifted_imm = 32'h8; stall = 1;
        @(negedge clk) st(32'h10, 0, 1, "trap_hold");
        idle(); trap_clr = 1;
        @(negedge clk) st(32'h100, 1, 0, "trap_clr");
        @(negedge clk) st(32'h104, 1, 0, "clr_in_run");
        idle(); stall = 1; branch = 1; zero = 1; shifted_imm = 32'h20;
        @(negedge clk) chk("stall1", pc, 32'h104);
        @(negedge clk) st(32'h104, 1, 0, "stall2");
        stall = 0;
        @(negedge clk) chk("stall_release", pc, 32'h124);
        idle(); branch = 1; zero = 0; shifted_imm = 32'h2;
        @(negedge clk) st(32'h128, 1, 0, "untaken_misaligned");
        idle(); jalr = 1; rs1_val = 32'h200; jump = 1; shifted_imm = 32'h6;
        @(negedge clk) st(32'h200, 1, 0, "prio_misalign_sel");
        idle(); jalr = 1; rs1_val = 32'hFFFF_FFF8; imm = 32'h4;
        @(negedge clk) chk("near_top", pc, 32'hFFFF_FFFC);
        chk("wrap_plus4", pc_plus4, 32'h0);
        idle();
        @(negedge clk) st(32'h0, 1, 0, "wrap");
        @(negedge clk) chk("pre_trap", pc, 32'h4);
        jump = 1; shifted_imm = 32'h2;
        @(negedge clk) st(32'h4, 0, 1, "trap2");
        idle();
        #2 rst_n = 0;
        #1 st(32'h0, 0, 0, "rst_in_trap");
        @(negedge clk) rst_n = 1;
        #1 st(32'h0, 0, 0, "boot2");
        @(negedge clk) st(32'h0, 1, 0, "run_after_rst");
        @(negedge clk) chk("run_after_rst4", pc, 32'h4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
